// File: rtl/counter_pkg.sv
// counter_pkg: shared counter mode constants and the modulo next-count step function.
package counter_pkg;
    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;
    localparam int CW = 32;

    // One extra bit of headroom lets a modulus of 2^width wrap without truncation.
    function automatic logic [CW:0] next_count(
        input logic [CW:0] count,
        input logic        up,
        input logic [CW:0] modulus,
        input logic        mode
    );
        logic [CW:0] top;
        top = modulus - (CW+1)'(1);
        if (up)
            return (count == top) ? ((mode == MODE_SAT) ? count : '0) : count + (CW+1)'(1);
        return (count == '0) ? ((mode == MODE_SAT) ? count : top) : count - (CW+1)'(1);
    endfunction
endpackage

// File: rtl/dff_bank.sv
// dff_bank: W-bit register with load enable and asynchronous active-low reset to RESET_VAL.
module dff_bank #(
    parameter int W         = 1,
    parameter int RESET_VAL = 0
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            o_q <= W'(RESET_VAL);
        else if (i_en)
            o_q <= i_d;
    end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: modulo-N up/down counter with clear, clamped load, wrap/saturate and sticky overflow.
module mod_counter import counter_pkg::*; #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_clamp;
    logic [WIDTH-1:0] w_d;
    logic             w_bnd;
    logic             w_cnt_en;
    logic             w_ovf_en;

    always_comb begin
        w_step   = WIDTH'(next_count((CW+1)'(count), up, (CW+1)'(MODULUS),
                                     (SATURATE != 0) ? MODE_SAT : MODE_WRAP));
        w_clamp  = ({1'b0, din} < (WIDTH+1)'(MODULUS)) ? din : TOP;
        w_d      = clr ? '0 : load ? w_clamp : w_step;
        w_cnt_en = clr | load | en;
        tc       = en & ((up & (count == TOP)) | (!up & (count == '0)));
        w_bnd    = tc & !clr & !load;
        // A boundary event in the same cycle as ovf_clr leaves the flag set.
        w_ovf_en = w_bnd | ovf_clr;
    end

    dff_bank #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_count (
        .i_clk (clk),
        .i_rstn(rstn),
        .i_en  (w_cnt_en),
        .i_d   (w_d),
        .o_q   (count)
    );

    dff_bank #(.W(1), .RESET_VAL(0)) u_ovf (
        .i_clk (clk),
        .i_rstn(rstn),
        .i_en  (w_ovf_en),
        .i_d   (w_bnd),
        .o_q   (ovf)
    );
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed checks of wrap, saturate, power-of-two and cascaded mod_counter instances.
module tb_mod_counter;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    logic       a_en = 0, a_up = 0, a_clr = 0, a_load = 0, a_ovf_clr = 0, a_tc, a_ovf;
    logic [3:0] a_din = 0, a_count;
    mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(0)) u_wrap (
        .clk(clk), .rstn(rstn), .en(a_en), .up(a_up), .clr(a_clr), .load(a_load),
        .din(a_din), .ovf_clr(a_ovf_clr), .count(a_count), .tc(a_tc), .ovf(a_ovf)
    );

    logic       s_en = 0, s_up = 0, s_clr = 0, s_load = 0, s_ovf_clr = 0, s_tc, s_ovf;
    logic [3:0] s_din = 0, s_count;
    mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(1)) u_sat (
        .clk(clk), .rstn(rstn), .en(s_en), .up(s_up), .clr(s_clr), .load(s_load),
        .din(s_din), .ovf_clr(s_ovf_clr), .count(s_count), .tc(s_tc), .ovf(s_ovf)
    );

    logic       p_en = 0, p_up = 0, p_load = 0, p_tc, p_ovf;
    logic [3:0] p_din = 0, p_count;
    mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0), .SATURATE(0)) u_p2 (
        .clk(clk), .rstn(rstn), .en(p_en), .up(p_up), .clr(1'b0), .load(p_load),
        .din(p_din), .ovf_clr(1'b0), .count(p_count), .tc(p_tc), .ovf(p_ovf)
    );

    logic       c_en = 0, lo_tc, lo_ovf, hi_tc, hi_ovf;
    logic [3:0] lo_count, hi_count;
    mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .rstn(rstn), .en(c_en), .up(1'b1), .clr(1'b0), .load(1'b0),
        .din(4'd0), .ovf_clr(1'b0), .count(lo_count), .tc(lo_tc), .ovf(lo_ovf)
    );
    mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .rstn(rstn), .en(lo_tc), .up(1'b1), .clr(1'b0), .load(1'b0),
        .din(4'd0), .ovf_clr(1'b0), .count(hi_count), .tc(hi_tc), .ovf(hi_ovf)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_count", 8'(a_count), 8'd0);
        check("rst_ovf", 8'(a_ovf), 8'd0);
        check("rst_tc", 8'(a_tc), 8'd0);
        @(negedge clk);
        rstn = 1'b1;

        // wrap mode counting up through 9 -> 0
        a_en = 1; a_up = 1;
        #1;
        for (int i = 0; i < 12; i++) begin
            check("up_tc", 8'(a_tc), (i % 10 == 9) ? 8'd1 : 8'd0);
            if (i == 9) check("up_ovf_pre", 8'(a_ovf), 8'd0);
            step();
            check("up_count", 8'(a_count), 8'((i + 1) % 10));
        end
        check("up_ovf_post", 8'(a_ovf), 8'd1);

        a_clr = 1;
        step();
        check("clr_en_count", 8'(a_count), 8'd0);
        check("clr_en_ovf", 8'(a_ovf), 8'd1);
        a_clr = 0; a_en = 0; a_ovf_clr = 1;
        step();
        check("ovf_clr", 8'(a_ovf), 8'd0);

        // down wrap with ovf_clr in the same cycle: set wins
        a_en = 1; a_up = 0;
        #1;
        check("dn_tc0", 8'(a_tc), 8'd1);
        step();
        check("dn_wrap", 8'(a_count), 8'd9);
        check("dn_ovf_setwins", 8'(a_ovf), 8'd1);
        a_ovf_clr = 0;
        check("dn_tc9", 8'(a_tc), 8'd0);
        step(); check("dn_8", 8'(a_count), 8'd8);
        step(); check("dn_7", 8'(a_count), 8'd7);
        step(); check("dn_6", 8'(a_count), 8'd6);

        // asynchronous reset between edges
        #3 rstn = 1'b0;
        #1;
        check("async_count", 8'(a_count), 8'd0);
        check("async_ovf", 8'(a_ovf), 8'd0);
        step();
        check("held_in_rst", 8'(a_count), 8'd0);
        @(negedge clk);
        rstn = 1'b1; a_up = 1;
        step();
        check("resume", 8'(a_count), 8'd1);

        a_en = 0; a_load = 1; a_din = 4'd5;
        step(); check("load5", 8'(a_count), 8'd5);
        a_din = 4'd12;
        step(); check("load12_clamp", 8'(a_count), 8'd9);
        a_en = 1; a_up = 1; a_din = 4'd3;
        #1; check("load_tc", 8'(a_tc), 8'd1);
        step();
        check("load_over_en", 8'(a_count), 8'd3);
        check("load_no_ovf", 8'(a_ovf), 8'd0);
        a_clr = 1; a_din = 4'd5;
        step(); check("clr_load", 8'(a_count), 8'd0);
        a_clr = 0; a_load = 0; a_en = 0; a_up = 0;
        step(); step();
        check("hold_count", 8'(a_count), 8'd0);
        check("hold_tc", 8'(a_tc), 8'd0);

        // saturate mode
        s_load = 1; s_din = 4'd7;
        step(); check("sat_load7", 8'(s_count), 8'd7);
        s_load = 0; s_en = 1; s_up = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_up", 8'(s_count), (i == 0) ? 8'd8 : 8'd9);
        end
        check("sat_tc", 8'(s_tc), 8'd1);
        check("sat_ovf", 8'(s_ovf), 8'd1);
        s_en = 0; s_clr = 1; s_ovf_clr = 1;
        step();
        check("sat_clr", 8'(s_count), 8'd0);
        check("sat_ovf_clr", 8'(s_ovf), 8'd0);
        s_clr = 0; s_ovf_clr = 0; s_en = 1; s_up = 0;
        #1; check("sat_dn_tc", 8'(s_tc), 8'd1);
        step(); check("sat_dn_hold", 8'(s_count), 8'd0);
        check("sat_dn_ovf", 8'(s_ovf), 8'd1);
        step(); check("sat_dn_hold2", 8'(s_count), 8'd0);

        // full power-of-two range
        p_load = 1; p_din = 4'd14;
        step(); check("p2_load14", 8'(p_count), 8'd14);
        p_load = 0; p_en = 1; p_up = 1;
        step(); check("p2_15", 8'(p_count), 8'd15);
        check("p2_tc", 8'(p_tc), 8'd1);
        step(); check("p2_wrap", 8'(p_count), 8'd0);
        check("p2_ovf", 8'(p_ovf), 8'd1);
        p_up = 0;
        step(); check("p2_dn_wrap", 8'(p_count), 8'd15);
        p_en = 0; p_load = 1; p_din = 4'd15;
        step(); check("p2_load15", 8'(p_count), 8'd15);
        p_load = 0;

        // cascade 00..99 -> 00
        c_en = 1;
        for (int i = 0; i < 100; i++) begin
            if (i == 99) check("casc_hi_tc", 8'(hi_tc), 8'd1);
            step();
            check("casc_val", 8'(hi_count) * 8'd10 + 8'(lo_count), 8'((i + 1) % 100));
            if (i == 98) check("casc_hi_ovf_pre", 8'(hi_ovf), 8'd0);
        end
        check("casc_hi_ovf", 8'(hi_ovf), 8'd1);
        c_en = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
